uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x fractional oversampling, 3-sample majority voting
// and a show-ahead receive FIFO with sticky framing/overrun flags.
module uart_rx_fifo #(
  parameter int unsigned CLKFREQ = 1000000,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic [31:0]              baud,
  input  logic                     rx,
  input  logic                     rd,
  input  logic                     clr_err,
  output logic                     valid,
  output logic [7:0]               data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     brk
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rs_q, rs_prev_q;
  logic [39:0] acc_q, acc_d, n;
  logic [3:0]  sc_q, sc_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        s7_q, s7_d, s8_q, s8_d;
  logic        ferr_q, ferr_d, ovr_q, ovr_d, brk_q, brk_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];

  logic tick, decide, vote, push, pop, we, full, empty, ferr_set, ovr_set;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
      rs_prev_q <= 1'b1;
      state_q   <= IDLE;
      acc_q     <= '0;
      sc_q      <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      brk_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
      rs_prev_q <= rs_q;
      state_q   <= state_d;
      acc_q     <= acc_d;
      sc_q      <= sc_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      brk_q     <= brk_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  // FIFO storage needs no reset: data is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (we) mem_q[wptr_q[AW-1:0]] <= shreg_q;
  end

  always_comb begin
    n        = acc_q + {4'b0, baud, 4'b0};
    tick     = (n >= 40'(CLKFREQ));
    acc_d    = tick ? (n - 40'(CLKFREQ)) : n;
    sc_d     = tick ? sc_q + 4'd1 : sc_q;
    decide   = tick && (sc_q == 4'd9);
    vote     = (s7_q & s8_q) | (s7_q & rs_q) | (s8_q & rs_q);
    s7_d     = (tick && sc_q == 4'd7) ? rs_q : s7_q;
    s8_d     = (tick && sc_q == 4'd8) ? rs_q : s8_q;
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    brk_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        sc_d = '0;
        if (rs_prev_q && !rs_q) begin
          state_d = START;
          acc_d   = '0;
        end
      end
      START: begin
        if (decide && vote) begin
          state_d = IDLE;
        end else if (tick && sc_q == 4'd15) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (decide) shreg_d = {vote, shreg_q[7:1]};
        if (tick && sc_q == 4'd15) begin
          if (bitcnt_q == 3'd7) state_d = STOP;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      STOP: begin
        if (decide) begin
          state_d = IDLE;
          if (vote) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
            brk_d    = (shreg_q == 8'h00);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop     = rd && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    we      = push && (!full || pop);
    ovr_set = push && full && !pop;
    wptr_d  = we  ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    ferr_d  = ferr_set | (ferr_q & ~clr_err);
    ovr_d   = ovr_set  | (ovr_q  & ~clr_err);
  end

  assign valid     = !empty;
  assign data      = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign level     = wptr_q - rptr_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign brk       = brk_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit (one oversample tick per clock).
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic [31:0] baud = 32'd100000;
  logic        rx = 1'b1;
  logic        rd = 1'b0;
  logic        clr_err = 1'b0;
  logic        valid;
  logic [7:0]  data;
  logic [3:0]  level;
  logic        busy, frame_err, overrun, brk;

  int total = 0;
  int passed = 0;
  int brk_cnt = 0;

  uart_rx_fifo #(.CLKFREQ(1600000), .DEPTH(8)) dut (
    .clk(clk), .resetq(resetq), .baud(baud), .rx(rx), .rd(rd), .clr_err(clr_err),
    .valid(valid), .data(data), .level(level), .busy(busy),
    .frame_err(frame_err), .overrun(overrun), .brk(brk)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (brk) brk_cnt++;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives one 10-bit frame; rd is asserted for the single cycle following posedge rd_cyc.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int rd_cyc);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int c = 0; c < 160; c++) begin
      @(posedge clk); #1;
      rx = frame[c/16];
      rd = (c == rd_cyc);
    end
    @(posedge clk); #1;
    rx = 1'b1;
    rd = 1'b0;
    idle(4);
  endtask

  task automatic pop_one();
    @(posedge clk); #1; rd = 1'b1;
    @(posedge clk); #1; rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    idle(3);
    @(negedge clk);
    if ({valid, level, data, busy, frame_err, overrun, brk} !== 17'h0)
      $display("FAIL reset_outputs got %h expected 0", {valid, level, data, busy, frame_err, overrun, brk});
    else passed++;
    total++;
    @(posedge clk); #1; resetq = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    send_byte(8'hA5, 1'b1, -1);
    @(negedge clk);
    if (valid !== 1'b1) $display("FAIL basic_valid got %b expected 1", valid); else passed++;
    total++;
    if (data !== 8'hA5) $display("FAIL basic_data got %h expected a5", data); else passed++;
    total++;
    if (level !== 4'd1) $display("FAIL basic_level got %0d expected 1", level); else passed++;
    total++;
    if (frame_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_flags got ferr=%b busy=%b expected 0 0", frame_err, busy);
    else passed++;
    total++;
    pop_one();
    @(negedge clk);
    if (valid !== 1'b0 || level !== 4'd0 || data !== 8'h00)
      $display("FAIL basic_pop got valid=%b level=%0d data=%h expected 0 0 00", valid, level, data);
    else passed++;
    total++;
  endtask

  task automatic test_glitch();
    @(posedge clk); #1; rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(4);
    @(negedge clk);
    if (busy !== 1'b1) $display("FAIL glitch_busy_start got %b expected 1", busy); else passed++;
    total++;
    idle(30);
    @(negedge clk);
    if (busy !== 1'b0 || level !== 4'd0)
      $display("FAIL glitch_abort got busy=%b level=%0d expected 0 0", busy, level);
    else passed++;
    total++;
  endtask

  task automatic test_frame_err();
    brk_cnt = 0;
    send_byte(8'h3C, 1'b0, -1);
    @(negedge clk);
    if (level !== 4'd0) $display("FAIL ferr_level got %0d expected 0", level); else passed++;
    total++;
    if (frame_err !== 1'b1) $display("FAIL ferr_set got %b expected 1", frame_err); else passed++;
    total++;
    if (brk_cnt !== 0) $display("FAIL ferr_no_brk got %0d pulses expected 0", brk_cnt); else passed++;
    total++;
    pulse_clr();
    @(negedge clk);
    if (frame_err !== 1'b0) $display("FAIL ferr_clear got %b expected 0", frame_err); else passed++;
    total++;
  endtask

  task automatic test_break();
    brk_cnt = 0;
    @(posedge clk); #1; rx = 1'b0;
    idle(12 * 16);
    rx = 1'b1;
    idle(32);
    @(negedge clk);
    if (frame_err !== 1'b1) $display("FAIL brk_ferr got %b expected 1", frame_err); else passed++;
    total++;
    if (brk_cnt !== 1) $display("FAIL brk_pulses got %0d expected 1", brk_cnt); else passed++;
    total++;
    if (level !== 4'd0) $display("FAIL brk_level got %0d expected 0", level); else passed++;
    total++;
    send_byte(8'h55, 1'b1, -1);
    @(negedge clk);
    if (data !== 8'h55 || level !== 4'd1)
      $display("FAIL brk_resume got data=%h level=%0d expected 55 1", data, level);
    else passed++;
    total++;
    pop_one();
    pulse_clr();
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1, -1);
    @(negedge clk);
    if (level !== 4'd8) $display("FAIL ovr_level got %0d expected 8", level); else passed++;
    total++;
    if (overrun !== 1'b1) $display("FAIL ovr_flag got %b expected 1", overrun); else passed++;
    total++;
    for (int i = 0; i < 8; i++) begin
      exp = 8'(i);
      @(negedge clk);
      if (data !== exp) $display("FAIL ovr_read%0d got %h expected %h", i, data, exp); else passed++;
      total++;
      pop_one();
    end
    @(negedge clk);
    if (valid !== 1'b0) $display("FAIL ovr_drained got %b expected 0", valid); else passed++;
    total++;
    pulse_clr();
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, -1);
    send_byte(8'h18, 1'b1, 156);
    @(negedge clk);
    if (overrun !== 1'b0 || level !== 4'd8)
      $display("FAIL full_pushpop got ovr=%b level=%0d expected 0 8", overrun, level);
    else passed++;
    total++;
    if (data !== 8'h11) $display("FAIL full_pushpop_head got %h expected 11", data); else passed++;
    total++;
  endtask

  task automatic test_reset_mid();
    logic [9:0] frame;
    frame = {1'b1, 8'hFF, 1'b0};
    for (int c = 0; c < 88; c++) begin
      @(posedge clk); #1;
      rx = frame[c/16];
    end
    @(negedge clk);
    if (busy !== 1'b1) $display("FAIL rstmid_busy_before got %b expected 1", busy); else passed++;
    total++;
    #1 resetq = 1'b0;
    #1;
    if ({valid, level, data, busy, frame_err, overrun, brk} !== 17'h0)
      $display("FAIL rstmid_async got %h expected 0", {valid, level, data, busy, frame_err, overrun, brk});
    else passed++;
    total++;
    idle(3);
    resetq = 1'b1;
    idle(80);
    @(negedge clk);
    if (busy !== 1'b0 || valid !== 1'b0)
      $display("FAIL rstmid_quiet got busy=%b valid=%b expected 0 0", busy, valid);
    else passed++;
    total++;
    send_byte(8'h81, 1'b1, -1);
    @(negedge clk);
    if (data !== 8'h81 || level !== 4'd1 || frame_err !== 1'b0)
      $display("FAIL rstmid_next got data=%h level=%0d ferr=%b expected 81 1 0", data, level, frame_err);
    else passed++;
    total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_break();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
